// File: rtl/seg_nibble_sequencer.sv
// Shows a handshaked byte on one 7-segment digit: hi nibble (dp lit), gap, lo nibble, gap.
// Outputs registered (hi digit one cycle after accept); ready_o only in IDLE, so valid_i may stay high.
module seg_nibble_sequencer #(
  parameter int DWELL_CYCLES = 1000000,
  parameter int BLANK_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       clear_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       busy_o
);

  localparam int MAXLEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW     = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, SHOW_HI, GAP_HI, SHOW_LO, GAP_LO} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      snap_q, snap_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
      4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
      4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
      4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
    endcase
  endfunction

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q != IDLE);
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    snap_d  = snap_q;
    seg_d   = '0;
    dp_d    = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (valid_i) begin
          state_d = SHOW_HI;
          snap_d  = value_i;
        end
        SHOW_HI: if (cnt_q == DWELL_LAST) state_d = (BLANK_CYCLES == 0) ? SHOW_LO : GAP_HI;
        GAP_HI:  if (cnt_q == BLANK_LAST) state_d = SHOW_LO;
        SHOW_LO: if (cnt_q == DWELL_LAST) state_d = (BLANK_CYCLES == 0) ? IDLE : GAP_LO;
        GAP_LO:  if (cnt_q == BLANK_LAST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // Counter restarts on every state entry; IDLE keeps it at zero.
    if (state_d != IDLE && state_d == state_q) cnt_d = cnt_q + CW'(1);
    case (state_d)
      SHOW_HI: begin
        seg_d = font(snap_d[7:4]);
        dp_d  = 1'b1;
      end
      SHOW_LO: seg_d = font(snap_d[3:0]);
      default: seg_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

endmodule
